uart_rx: RTL



---
 rtl/uart_rx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with valid/ready byte output.
// Flags stop-bit framing errors and overruns of an unaccepted byte.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OSR       = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OSR);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(OSR / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OSR - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 rx_m, rx_s;
  logic                 stop_ok, stop_bad;
  logic                 accept, load;

  assign accept = rx_valid && rx_ready;
  assign load   = stop_ok && (!rx_valid || rx_ready);

  // two-flop synchronizer for the asynchronous line, idles high
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // frame state, oversample counter, bit index and shift register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  // next-state logic; only oversample ticks advance the frame
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (tick_16x) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt_n   = '0;
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            idx_n   = idx + 1'b1;
            if (idx == LAST) state_n = STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL) begin
            cnt_n    = '0;
            state_n  = IDLE;
            stop_ok  = rx_s;
            stop_bad = !rx_s;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // output byte register, handshake and one-cycle error pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
      frame_err <= stop_bad;
      overrun   <= stop_ok && rx_valid && !rx_ready;
    end
  end

endmodule
